// File: rtl/product_accumulator_if.sv
// Streaming bus between the multiplier output and the product accumulator.
// Carries the input product stream and the output group-result stream.
interface product_accumulator_if #(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 48,
   parameter int CNT_WIDTH = 3
);
   // Valid/ready on both streams: a beat moves on a rising edge where valid
   // and ready are both high; the source holds valid and its payload stable
   // until that edge, and valid never waits on ready.
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_data;
   logic [CNT_WIDTH-1:0] out_count;
   logic                 out_ovf;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count, out_ovf
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of up to COUNT unsigned products into an ACC_WIDTH-bit result,
// closing a group after COUNT beats or early on in_last.
module product_accumulator #(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 48,
   parameter int COUNT     = 4,
   parameter int CNT_WIDTH = $clog2(COUNT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   product_accumulator_if.slave  bus,
   output logic                  state_o
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] COUNT_C = CNT_WIDTH'(COUNT);

   state_t               state_q;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 ovf_q;
   logic [ACC_WIDTH-1:0] out_data_q;
   logic [CNT_WIDTH-1:0] out_count_q;
   logic                 out_ovf_q;

   logic                 in_ready;
   logic                 beat;
   logic                 xfer;
   logic                 close;
   logic                 carry;
   logic [ACC_WIDTH-1:0] sum;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 ovf_next;

   // acc/cnt/ovf are zero whenever a group is empty (including all of HOLD),
   // so the same adder serves both the first beat and later beats.
   always_comb begin
      in_ready     = (state_q == ST_ACCUM) ? 1'b1 : bus.out_ready;
      beat         = bus.in_valid & in_ready;
      xfer         = (state_q == ST_HOLD) & bus.out_ready;
      {carry, sum} = {1'b0, acc_q} + (ACC_WIDTH + 1)'(bus.in_data);
      cnt_inc      = cnt_q + 1'b1;
      close        = beat & ((cnt_inc == COUNT_C) | bus.in_last);
      ovf_next     = ovf_q | carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: state_q <= ST_ACCUM;
            ST_HOLD:  if (xfer) state_q <= ST_ACCUM;
            default:  state_q <= ST_ACCUM;
         endcase
         // A beat accepted in HOLD implies a transfer, so it is handled
         // exactly like a beat in ACCUM; a closing beat re-enters HOLD.
         if (beat) begin
            if (close) begin
               out_data_q  <= sum;
               out_count_q <= cnt_inc;
               out_ovf_q   <= ovf_next;
               acc_q       <= '0;
               cnt_q       <= '0;
               ovf_q       <= 1'b0;
               state_q     <= ST_HOLD;
            end else begin
               acc_q <= sum;
               cnt_q <= cnt_inc;
               ovf_q <= ovf_next;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign bus.out_ovf   = out_ovf_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three configurations (default,
// 17-bit accumulator, COUNT=1) checked against a small reference model.
module tb_product_accumulator;

   logic clk;
   logic rst_n;
   logic st_a, st_b, st_c;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Expected results packed as {7'b0, ovf, 8-bit count, 48-bit data}.
   logic [63:0] exp_a_q[$];
   logic [63:0] exp_b_q[$];
   logic [63:0] exp_c_q[$];

   logic [48:0] m_acc [3];
   int          m_cnt [3];
   logic        m_ovf [3];
   int          m_aw  [3] = '{48, 17, 48};
   int          m_lim [3] = '{4, 4, 1};

   product_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(48), .CNT_WIDTH(3)) ia ();
   product_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(3)) ib ();
   product_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(48), .CNT_WIDTH(1)) ic ();

   product_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(48), .COUNT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ia), .state_o(st_a));
   product_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(17), .COUNT(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ib), .state_o(st_b));
   product_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(48), .COUNT(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(ic), .state_o(st_c));

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic ovf, input int cnt, input logic [47:0] data);
      return {7'b0, ovf, 8'(cnt), data};
   endfunction

   task automatic drive(input int w, input logic v, input logic [15:0] d, input logic last);
      case (w)
         0: begin ia.in_valid = v; ia.in_data = d; ia.in_last = last; end
         1: begin ib.in_valid = v; ib.in_data = d; ib.in_last = last; end
         default: begin ic.in_valid = v; ic.in_data = d; ic.in_last = last; end
      endcase
   endtask

   task automatic set_ordy(input int w, input logic r);
      case (w)
         0: ia.out_ready = r;
         1: ib.out_ready = r;
         default: ic.out_ready = r;
      endcase
   endtask

   function automatic logic rdy(input int w);
      case (w)
         0: return ia.in_ready;
         1: return ib.in_ready;
         default: return ic.in_ready;
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = '0;
         m_cnt[i] = 0;
         m_ovf[i] = 1'b0;
      end
      exp_a_q.delete();
      exp_b_q.delete();
      exp_c_q.delete();
   endtask

   task automatic model_beat(input int w, input logic [15:0] d, input logic last);
      logic [48:0] s;
      logic [48:0] mask;
      logic [63:0] e;
      mask = (49'd1 << m_aw[w]) - 49'd1;
      s = m_acc[w] + {33'b0, d};
      m_ovf[w] = m_ovf[w] | s[m_aw[w]];
      m_acc[w] = s & mask;
      m_cnt[w] = m_cnt[w] + 1;
      if (m_cnt[w] == m_lim[w] || last) begin
         e = pack(m_ovf[w], m_cnt[w], m_acc[w][47:0]);
         case (w)
            0: exp_a_q.push_back(e);
            1: exp_b_q.push_back(e);
            default: exp_c_q.push_back(e);
         endcase
         m_acc[w] = '0;
         m_cnt[w] = 0;
         m_ovf[w] = 1'b0;
      end
   endtask

   // Called #1 after a rising edge; returns with inputs changed #1 after the
   // accepting edge, and the number of cycles in_ready was low.
   task automatic send(input int w, input logic [15:0] d, input logic last, output int waited);
      logic accepted;
      waited   = 0;
      accepted = 1'b0;
      drive(w, 1'b1, d, last);
      while (!accepted && waited < 50) begin
         @(negedge clk);
         accepted = rdy(w);
         @(posedge clk);
         #1;
         if (!accepted) waited++;
      end
      check("beat_accepted", 64'(accepted), 64'd1);
      if (accepted) model_beat(w, d, last);
      drive(w, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic send_nb(input int w, input logic [15:0] d, input logic last);
      int wt;
      send(w, d, last, wt);
      check("no_bubble", 64'(wt), 64'd0);
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (rst_n && ia.out_valid && ia.out_ready) begin
         check("sb_a_pending", 64'(exp_a_q.size() != 0), 64'd1);
         if (exp_a_q.size() != 0)
            check("sb_a_result", pack(ia.out_ovf, int'(ia.out_count), ia.out_data), exp_a_q.pop_front());
      end
      if (rst_n && ib.out_valid && ib.out_ready) begin
         check("sb_b_pending", 64'(exp_b_q.size() != 0), 64'd1);
         if (exp_b_q.size() != 0)
            check("sb_b_result", pack(ib.out_ovf, int'(ib.out_count), {31'b0, ib.out_data}), exp_b_q.pop_front());
      end
      if (rst_n && ic.out_valid && ic.out_ready) begin
         check("sb_c_pending", 64'(exp_c_q.size() != 0), 64'd1);
         if (exp_c_q.size() != 0)
            check("sb_c_result", pack(ic.out_ovf, int'(ic.out_count), ic.out_data), exp_c_q.pop_front());
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      for (int w = 0; w < 3; w++) begin
         drive(w, 1'b0, 16'h0, 1'b0);
         set_ordy(w, 1'b1);
      end
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(ia.out_valid), 64'd0);
      check("rst_in_ready", 64'(ia.in_ready), 64'd1);
      check("rst_state", 64'(st_a), 64'd0);
      check("rst_out_data", 64'(ia.out_data), 64'd0);
      check("rst_out_count", 64'(ia.out_count), 64'd0);
      check("rst_out_ovf", 64'(ia.out_ovf), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full group of four, result one cycle after the closing beat.
      send_nb(0, 16'd1, 1'b0);
      send_nb(0, 16'd2, 1'b0);
      send_nb(0, 16'd3, 1'b0);
      send_nb(0, 16'd4, 1'b0);
      check("t1_out_valid", 64'(ia.out_valid), 64'd1);
      check("t1_out_data", 64'(ia.out_data), 64'd10);
      check("t1_out_count", 64'(ia.out_count), 64'd4);
      check("t1_out_ovf", 64'(ia.out_ovf), 64'd0);

      // Early close on in_last, then a count-closed group without a gap.
      send_nb(0, 16'hFFFF, 1'b0);
      send_nb(0, 16'hFFFF, 1'b1);
      check("t2_out_data", 64'(ia.out_data), 64'h1FFFE);
      check("t2_out_count", 64'(ia.out_count), 64'd2);
      for (int i = 0; i < 4; i++) send_nb(0, 16'd7, 1'b0);
      check("t2b_out_data", 64'(ia.out_data), 64'd28);
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: result held while the next beat waits.
      set_ordy(0, 1'b0);
      send_nb(0, 16'd2, 1'b0);
      send_nb(0, 16'd3, 1'b1);
      drive(0, 1'b1, 16'd9, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_in_ready_low", 64'(ia.in_ready), 64'd0);
         check("t3_out_valid", 64'(ia.out_valid), 64'd1);
         check("t3_out_data_stable", 64'(ia.out_data), 64'd5);
         @(posedge clk);
         #1;
      end
      set_ordy(0, 1'b1);
      send_nb(0, 16'd9, 1'b0);
      check("t3_state_after_xfer", 64'(st_a), 64'd0);
      check("t3_out_valid_after_xfer", 64'(ia.out_valid), 64'd0);
      for (int i = 0; i < 3; i++) send_nb(0, 16'd1, 1'b0);
      check("t3_out_data_12", 64'(ia.out_data), 64'd12);
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset mid-group discards the partial sum.
      send_nb(0, 16'd5, 1'b0);
      send_nb(0, 16'd6, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", 64'(ia.out_valid), 64'd0);
      check("t5_rst_in_ready", 64'(ia.in_ready), 64'd1);
      check("t5_rst_out_data", 64'(ia.out_data), 64'd0);
      check("t5_rst_state", 64'(st_a), 64'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send_nb(0, 16'd5, 1'b0);
      check("t5_out_data", 64'(ia.out_data), 64'd20);
      check("t5_out_count", 64'(ia.out_count), 64'd4);

      // 17-bit accumulator: overflow is sticky per group only.
      for (int i = 0; i < 4; i++) send_nb(1, 16'hFFFF, 1'b0);
      check("t4_out_data", 64'(ib.out_data), 64'h1FFFC);
      check("t4_out_ovf", 64'(ib.out_ovf), 64'd1);
      for (int i = 0; i < 4; i++) send_nb(1, 16'd1, 1'b0);
      check("t4b_out_data", 64'(ib.out_data), 64'd4);
      check("t4b_out_ovf", 64'(ib.out_ovf), 64'd0);

      // COUNT=1: every beat is a result, back to back.
      send_nb(2, 16'd3, 1'b0);
      check("t6_valid_3", 64'(ic.out_valid), 64'd1);
      send_nb(2, 16'd4, 1'b0);
      check("t6_valid_4", 64'(ic.out_valid), 64'd1);
      check("t6_data_4", 64'(ic.out_data), 64'd4);
      send_nb(2, 16'd5, 1'b0);
      check("t6_data_5", 64'(ic.out_data), 64'd5);
      check("t6_count", 64'(ic.out_count), 64'd1);

      repeat (4) @(posedge clk);
      #1;
      check("drain_a", 64'(exp_a_q.size()), 64'd0);
      check("drain_b", 64'(exp_b_q.size()), 64'd0);
      check("drain_c", 64'(exp_c_q.size()), 64'd0);
      check("idle_c_out_valid", 64'(ic.out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
